led_brightness_sequencer: RTL and testbench

//   Sequences the LED brightness datapath from two raw push-buttons. Synchronises and

---
 rtl/led_brightness_sequencer.sv | 164 ++++++++++++++++
 tb/tb_led_brightness_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_brightness_sequencer.sv
// ----------------------------------------------------------------------------
// led_brightness_sequencer : two-button debounced brightness stepper with
//                            auto-repeat and glitch-free PWM LED drive
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module led_brightness_sequencer #(
  parameter int LVL_W       = 3,
  parameter int DEB_CYCLES  = 4,
  parameter int REPEAT_DLY  = 16,
  parameter int REPEAT_RATE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bright_up,
  input  logic             bright_down,
  output logic [LVL_W-1:0] level,
  output logic             led,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [LVL_W-1:0] LVL_MAX  = '1;
  localparam logic [LVL_W-1:0] PWM_LAST = LVL_MAX - 1'b1;
  localparam int DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int TMR_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [TMR_W-1:0] DLY_LOAD  = TMR_W'(REPEAT_DLY - 1);
  localparam logic [TMR_W-1:0] RATE_LOAD = TMR_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  // Bit 0 is the up button, bit 1 the down button throughout.
  logic [1:0]            raw;
  logic [1:0]            s1;
  logic [1:0]            s2;
  logic [1:0]            db;
  logic [1:0]            db_d;
  logic [1:0]            armed;
  logic [1:0]            rise;
  logic [1:0]            warm;
  logic [1:0][DEB_W-1:0] deb_cnt;

  state_t                state;
  logic                  dir;
  logic [TMR_W-1:0]      timer;

  logic [LVL_W-1:0]      pwm_cnt;
  logic [LVL_W-1:0]      duty;

  assign raw = {bright_down, bright_up};

  // A button only becomes armed once its synchronised input has been seen
  // released after reset, so a button still held through reset cannot step.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1      <= '0;
      s2      <= '0;
      db      <= '0;
      db_d    <= '0;
      deb_cnt <= '0;
      warm    <= '0;
      armed   <= '0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      db_d <= db;
      if (warm != 2'd2) begin
        warm <= warm + 2'd1;
      end
      for (int b = 0; b < 2; b++) begin
        if (s2[b] != db[b]) begin
          if (deb_cnt[b] == DEB_LAST) begin
            db[b]      <= s2[b];
            deb_cnt[b] <= '0;
          end else begin
            deb_cnt[b] <= deb_cnt[b] + 1'b1;
          end
        end else begin
          deb_cnt[b] <= '0;
        end
        if ((warm == 2'd2) && !s2[b]) begin
          armed[b] <= 1'b1;
        end
      end
    end
  end

  assign rise = db & ~db_d & armed;

  function automatic logic [LVL_W-1:0] stepped(input logic [LVL_W-1:0] lv,
                                               input logic down);
    if (down) begin
      return (lv == '0) ? lv : lv - 1'b1;
    end
    return (lv == LVL_MAX) ? lv : lv + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      dir   <= 1'b0;
      timer <= '0;
      level <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise[0] && !db[1]) begin
            level <= stepped(level, 1'b0);
            dir   <= 1'b0;
            timer <= DLY_LOAD;
            state <= HOLD;
          end else if (rise[1] && !db[0]) begin
            level <= stepped(level, 1'b1);
            dir   <= 1'b1;
            timer <= DLY_LOAD;
            state <= HOLD;
          end
        end
        HOLD, REPEAT: begin
          if (!db[dir] || db[~dir]) begin
            state <= IDLE;
          end else if (timer == '0) begin
            level <= stepped(level, dir);
            timer <= RATE_LOAD;
            state <= REPEAT;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Duty only changes at the period boundary so every PWM period is whole.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= '0;
      duty    <= '0;
      led     <= 1'b0;
    end else begin
      led <= (pwm_cnt < duty);
      if (pwm_cnt == PWM_LAST) begin
        pwm_cnt <= '0;
        duty    <= level;
      end else begin
        pwm_cnt <= pwm_cnt + 1'b1;
      end
    end
  end

  assign at_max = (level == LVL_MAX);
  assign at_min = (level == '0);

endmodule

`default_nettype wire

// File: tb/tb_led_brightness_sequencer.sv
// ----------------------------------------------------------------------------
// tb_led_brightness_sequencer : directed + random bench against a rule model
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_led_brightness_sequencer;

  localparam int LVL_W       = 3;
  localparam int DEB_CYCLES  = 4;
  localparam int REPEAT_DLY  = 16;
  localparam int REPEAT_RATE = 8;
  localparam int LMAX        = 2**LVL_W - 1;
  localparam int PERIOD      = 2**LVL_W - 1;

  logic             clk;
  logic             reset;
  logic             bright_up;
  logic             bright_down;
  logic [LVL_W-1:0] level;
  logic             led;
  logic             at_max;
  logic             at_min;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  led_brightness_sequencer #(
    .LVL_W      (LVL_W),
    .DEB_CYCLES (DEB_CYCLES),
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_RATE(REPEAT_RATE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bright_up  (bright_up),
    .bright_down(bright_down),
    .level      (level),
    .led        (led),
    .at_max     (at_max),
    .at_min     (at_min)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: values held after the most recent clock edge.
  bit m_s1[2];
  bit m_s2[2];
  bit m_db[2];
  bit m_db_d[2];
  bit m_arm[2];
  bit hist_u[$];
  bit hist_d[$];
  int m_since;
  int m_level;
  bit m_led;
  int m_phase;
  int m_duty;
  bit m_active;
  bit m_dir;
  int m_held;

  function automatic int sat(input int v);
    if (v > LMAX) return LMAX;
    if (v < 0) return 0;
    return v;
  endfunction

  function automatic bit all_differ(input bit q[$], input bit v);
    if (q.size() < DEB_CYCLES) return 1'b0;
    foreach (q[i]) if (q[i] == v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge(input bit up, input bit dn, input bit rst);
    bit s2p[2];
    bit dbp[2];
    bit dbdp[2];
    bit armp[2];
    bit rise[2];
    int lvlp;
    if (rst) begin
      m_s1 = '{0, 0}; m_s2 = '{0, 0}; m_db = '{0, 0}; m_db_d = '{0, 0}; m_arm = '{0, 0};
      hist_u.delete(); hist_d.delete();
      m_since = 0; m_level = 0; m_led = 0; m_phase = 0; m_duty = 0;
      m_active = 0; m_dir = 0; m_held = 0;
      return;
    end
    s2p = m_s2; dbp = m_db; dbdp = m_db_d; armp = m_arm; lvlp = m_level;
    // Stepping: one step on a clean fresh press, then at fixed hold durations.
    if (!m_active) begin
      for (int b = 0; b < 2; b++) rise[b] = dbp[b] && !dbdp[b] && armp[b];
      if (rise[0] && !dbp[1]) begin
        m_level = sat(lvlp + 1); m_active = 1; m_dir = 0; m_held = 0;
      end else if (rise[1] && !dbp[0]) begin
        m_level = sat(lvlp - 1); m_active = 1; m_dir = 1; m_held = 0;
      end
    end else if (!dbp[m_dir] || dbp[1 - m_dir]) begin
      m_active = 0;
    end else begin
      m_held++;
      if (m_held == REPEAT_DLY ||
          (m_held > REPEAT_DLY && (m_held - REPEAT_DLY) % REPEAT_RATE == 0))
        m_level = sat(lvlp + (m_dir ? -1 : 1));
    end
    m_led = (m_phase < m_duty);
    if (m_phase == PERIOD - 1) begin
      m_phase = 0; m_duty = lvlp;
    end else begin
      m_phase++;
    end
    // Debounce as a window: flip after DEB_CYCLES consecutive differing samples.
    m_db_d = dbp;
    hist_u.push_back(s2p[0]); if (hist_u.size() > DEB_CYCLES) void'(hist_u.pop_front());
    hist_d.push_back(s2p[1]); if (hist_d.size() > DEB_CYCLES) void'(hist_d.pop_front());
    if (all_differ(hist_u, dbp[0])) m_db[0] = !dbp[0];
    if (all_differ(hist_d, dbp[1])) m_db[1] = !dbp[1];
    for (int b = 0; b < 2; b++) if (m_since >= 2 && !s2p[b]) m_arm[b] = 1;
    if (m_since < 2) m_since++;
    m_s2 = m_s1;
    m_s1[0] = up; m_s1[1] = dn;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit up, input bit dn, input bit rst);
    bright_up   = up;
    bright_down = dn;
    reset       = rst;
    @(posedge clk);
    model_edge(up, dn, rst);
    #1;
    chk("level", 32'(level), 32'(m_level));
    chk("led", 32'(led), 32'(m_led));
    chk("at_max", 32'(at_max), 32'(m_level == LMAX));
    chk("at_min", 32'(at_min), 32'(m_level == 0));
  endtask

  task automatic ticks(input int n, input bit up, input bit dn);
    for (int i = 0; i < n; i++) tick(up, dn, 1'b0);
  endtask

  initial begin
    int hi;
    int guard;
    int len;
    int sel;
    bright_up = 0; bright_down = 0; reset = 1;

    // Reset held for three clocks with buttons idle.
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 1);
      chk("rst_level", 32'(level), 0);
      chk("rst_led", 32'(led), 0);
      chk("rst_at_min", 32'(at_min), 1);
      chk("rst_at_max", 32'(at_max), 0);
    end
    ticks(4, 0, 0);

    // Short pulses are rejected by the debouncer.
    tick(1, 0, 0);
    ticks(6, 0, 0);
    ticks(3, 1, 0);
    ticks(10, 0, 0);
    chk("glitch_level", 32'(level), 0);

    // Single step latency: level changes six edges after the first sample.
    for (int i = 0; i < 7; i++) begin
      tick(1, 0, 0);
      if (i == 5) chk("step_early", 32'(level), 0);
      if (i == 6) chk("step_latency", 32'(level), 1);
    end
    ticks(3, 1, 0);
    ticks(14, 0, 0);
    hi = 0;
    for (int i = 0; i < PERIOD; i++) begin
      tick(0, 0, 0);
      hi += int'(led);
    end
    chk("duty_lvl1", 32'(hi), 1);

    // Long hold up saturates at max, then long hold down saturates at zero.
    ticks(100, 1, 0);
    chk("sat_max", 32'(level), 7);
    chk("sat_at_max", 32'(at_max), 1);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1, 0, 0);
      hi += int'(led);
    end
    chk("led_full", 32'(hi), 10);
    ticks(10, 0, 0);
    ticks(100, 0, 1);
    chk("sat_min", 32'(level), 0);
    chk("sat_at_min", 32'(at_min), 1);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      tick(0, 1, 0);
      hi += int'(led);
    end
    chk("led_off", 32'(hi), 0);
    ticks(10, 0, 0);

    // Second button cancels a hold; nothing resumes without a fresh press.
    ticks(10, 1, 0);
    ticks(20, 1, 1);
    ticks(40, 1, 0);
    chk("cancel_hold", 32'(level), 1);
    ticks(10, 0, 0);
    ticks(40, 1, 1);
    chk("both_press", 32'(level), 1);
    ticks(10, 0, 0);

    // Reset during auto-repeat; a button held through reset is locked out.
    guard = 0;
    while (m_level != 5 && guard < 100) begin
      tick(1, 0, 0);
      guard++;
    end
    chk("reach_lvl5", 32'(level), 5);
    tick(1, 0, 1);
    chk("midrst_level", 32'(level), 0);
    chk("midrst_led", 32'(led), 0);
    ticks(40, 1, 0);
    chk("held_thru_rst", 32'(level), 0);
    ticks(12, 0, 0);
    ticks(12, 1, 0);
    chk("fresh_press", 32'(level), 1);
    ticks(6, 0, 0);

    // Random button activity with occasional resets.
    for (int seg = 0; seg < 150; seg++) begin
      if ($urandom_range(0, 24) == 0) begin
        tick(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1);
      end else begin
        len = $urandom_range(1, 30);
        sel = $urandom_range(0, 3);
        ticks(len, sel[0], sel[1]);
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
